shift_sched: RTL and testbench
==============================

# shift_sched

Arbitrating load scheduler for the 4-bit serial-in shift register stage. Two requesters each submit a parallel word. The block grants one requester round-robin and serializes the word LSB-first into the shift register's serial input. It then reads the parallel output back and returns it to the granted requester with a match flag confirming the load.

## Interface
- WIDTH, 4, shift register length in bits, and width of each request word; must be ≥ 2.
- clk  in  1  system clock, rising-edge.
- rst  in  1  reset, asynchronous, active-low.
- req0, req1  in  1  load requests; level, held until the matching gnt pulse.
- data0, data1  in  WIDTH  words to load; sampled only on the accepting edge.
- sr_q  in  WIDTH  parallel output of the shift register.
- sr_en  out  1  shift enable; the register shifts {sr_din, q[WIDTH-1:1]} only on edges where sr_en=1.
- sr_din  out  1  serial bit to the shift register.
- gnt0, gnt1  out  1  one-cycle acceptance pulse to the winning requester.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.
- done_id  out  1  requester served (0/1); valid while done=1 and held until the next done.
- rdata  out  WIDTH  sr_q captured at completion; held until the next done.
- match  out  1  rdata equals the latched word; held until the next done.

## Operation
- FSM states: IDLE, SHIFT, CHECK, DONE. All outputs are registered or decoded from registers only; there are no combinational paths from inputs to outputs.
- IDLE: on an edge with req0|req1=1:
  - select the winner;
  - latch its data into shadow and expected registers;
  - cnt←0;
  - pulse its gnt;
  - go to SHIFT.
- Winner selection:
  - A single requester wins.
  - When both request, the requester other than last_id wins.
  - last_id updates to the winner on every accept.
- SHIFT:
  - sr_en=1 and sr_din=shadow[0].
  - On each edge, shadow shifts right by one and cnt increments.
  - After WIDTH edges (cnt=WIDTH-1 → wrap), go to CHECK.
  - Because the register shifts in at the MSB, after WIDTH shifts sr_q equals the latched word.
- CHECK:
  - sr_en=0; sr_q is stable.
  - On the next edge: rdata←sr_q, match←(sr_q==expected), done_id←winner; go to DONE.
- DONE: done=1 for one cycle, then go to IDLE.
- req is ignored outside IDLE. A req still high in IDLE after done counts as a new request.
- cnt is $clog2(WIDTH) bits wide and wraps only from WIDTH-1 to 0.
- No shift register clear is needed; a full transaction overwrites all WIDTH bits.

## Timing
- Label the accepting edge E0:
  - gnt is high during cycle E0→E1.
  - sr_en is high from E0 to EWIDTH, i.e. exactly WIDTH cycles.
  - Shift register captures occur on edges E1…EWIDTH.
  - CHECK occupies EWIDTH→EWIDTH+1.
  - rdata, match and done_id update at EWIDTH+1.
  - done is high EWIDTH+1→EWIDTH+2.
  - IDLE resumes at EWIDTH+2.
  - The next accept can occur at EWIDTH+3 at the earliest.
- Back-to-back period is WIDTH+3 cycles (7 for WIDTH=4).
- Reset, rst=0, asynchronous, effective immediately:
  - state IDLE, cnt=0, shadow=0, expected=0, last_id=1 (req0 wins the first tie);
  - sr_en, sr_din, gnt0, gnt1, busy, done, done_id, rdata and match are all 0.
- Reset mid-transaction aborts it: no done is issued and the partial shift register contents are irrelevant.
- Reset release is synchronous to clk externally; the first accept may occur on the first rising edge with rst=1.

## Test plan
- Reset: drive rst=0 with random inputs → all outputs 0, busy=0. Release → idle with no activity until a req.
- Single load: req0=1, data0=4'b1011 →
  - gnt0 pulses after E0;
  - sr_din sequence 1,1,0,1 over 4 sr_en cycles;
  - done at E5→E6 with done_id=0, rdata=4'b1011, match=1.
- Contention: req0=req1=1 held, data0=4'h3, data1=4'hC →
  - grants alternate 0,1,0,1 with accepts every 7 cycles;
  - done_id alternates;
  - rdata alternates 3, C, with match=1 each time.
- Fault: shift register model with bit 2 stuck-at-0, data1=4'hF → rdata=4'hB, match=0, done_id=1.
- Abort: reset asserted on the 2nd SHIFT cycle →
  - sr_en drops asynchronously and no done pulse occurs;
  - after release, req0=req1=1 → req0 granted first.
- Data stability: change data0 from 4'h5 to 4'hA one cycle after gnt0 → rdata=4'h5, match=1.

Source files
------------

// File: rtl/shift_sched_if.sv
// Handshake and shift-register bus between requesters, scheduler and the serial-in shift register.
// The master side is the requesters plus the shift register; the slave side is the scheduler.
interface shift_sched_if #(parameter int WIDTH = 4);
    logic             req0;
    logic             req1;
    logic [WIDTH-1:0] data0;
    logic [WIDTH-1:0] data1;
    logic [WIDTH-1:0] sr_q;
    logic             sr_en;
    logic             sr_din;
    logic             gnt0;
    logic             gnt1;
    logic             busy;
    logic             done;
    logic             done_id;
    logic [WIDTH-1:0] rdata;
    logic             match;

    modport master (
        output req0, req1, data0, data1, sr_q,
        input  sr_en, sr_din, gnt0, gnt1, busy, done, done_id, rdata, match
    );

    modport slave (
        input  req0, req1, data0, data1, sr_q,
        output sr_en, sr_din, gnt0, gnt1, busy, done, done_id, rdata, match
    );
endinterface

// File: rtl/shift_sched.sv
// Round-robin load scheduler: grants one of two requesters, shifts its word LSB-first
// into a serial-in shift register, then reads the register back and flags a match.
module shift_sched #(
    parameter int WIDTH = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    shift_sched_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, SHIFT, CHECK, DONE} state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_shadow;
    logic [WIDTH-1:0] r_expected;
    logic [WIDTH-1:0] r_rdata;
    logic             r_last_id;
    logic             r_winner;
    logic             r_gnt0;
    logic             r_gnt1;
    logic             r_done_id;
    logic             r_match;
    logic             w_accept;
    logic             w_pick1;
    logic             w_cnt_last;

    assign w_accept   = (r_state == IDLE) && (bus.req0 || bus.req1);
    // On a tie the requester that did not win last time is picked.
    assign w_pick1    = bus.req1 && (!bus.req0 || !r_last_id);
    assign w_cnt_last = (r_cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_state_next = SHIFT;
            SHIFT:   if (w_cnt_last) w_state_next = CHECK;
            CHECK:   w_state_next = DONE;
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt      <= '0;
            r_shadow   <= '0;
            r_expected <= '0;
            r_rdata    <= '0;
            r_last_id  <= 1'b1;
            r_winner   <= 1'b0;
            r_gnt0     <= 1'b0;
            r_gnt1     <= 1'b0;
            r_done_id  <= 1'b0;
            r_match    <= 1'b0;
        end else begin
            r_gnt0 <= 1'b0;
            r_gnt1 <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_winner   <= w_pick1;
                        r_last_id  <= w_pick1;
                        r_shadow   <= w_pick1 ? bus.data1 : bus.data0;
                        r_expected <= w_pick1 ? bus.data1 : bus.data0;
                        r_cnt      <= '0;
                        r_gnt0     <= !w_pick1;
                        r_gnt1     <= w_pick1;
                    end
                end
                SHIFT: begin
                    r_shadow <= {1'b0, r_shadow[WIDTH-1:1]};
                    r_cnt    <= w_cnt_last ? '0 : r_cnt + 1'b1;
                end
                CHECK: begin
                    r_rdata   <= bus.sr_q;
                    r_match   <= (bus.sr_q == r_expected);
                    r_done_id <= r_winner;
                end
                default: ;
            endcase
        end
    end

    // Outputs decode the state register; sr_din is gated so it idles low outside SHIFT.
    assign bus.sr_en   = (r_state == SHIFT);
    assign bus.sr_din  = (r_state == SHIFT) && r_shadow[0];
    assign bus.busy    = (r_state != IDLE);
    assign bus.done    = (r_state == DONE);
    assign bus.gnt0    = r_gnt0;
    assign bus.gnt1    = r_gnt1;
    assign bus.done_id = r_done_id;
    assign bus.rdata   = r_rdata;
    assign bus.match   = r_match;
endmodule

// File: tb/tb_shift_sched.sv
// Directed bench for shift_sched with a behavioural serial-in shift register that can
// model stuck-at-0 bits on its parallel output.
module tb_shift_sched;
    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] stuck;
    logic [W-1:0] sr_reg;
    int           cyc = 0;
    int           n_vec = 0;
    int           n_checks = 0;
    int           n_err = 0;

    shift_sched_if #(.WIDTH(W)) bus ();

    shift_sched #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (bus.sr_en) sr_reg <= {bus.sr_din, sr_reg[W-1:1]};
    end
    assign bus.sr_q = sr_reg & ~stuck;

    typedef struct {
        logic         r0;
        logic         r1;
        logic [W-1:0] d0;
        logic [W-1:0] d1;
        logic [W-1:0] dlate;
        logic [W-1:0] stuck;
        logic         eid;
        logic [W-1:0] erdata;
        logic         ematch;
    } vec_t;

    vec_t tbl [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic run_txn(input vec_t v);
        logic         got;
        logic [W-1:0] w;
        @(negedge clk);
        bus.req0  = v.r0;
        bus.req1  = v.r1;
        bus.data0 = v.d0;
        bus.data1 = v.d1;
        stuck     = v.stuck;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(posedge clk); #1;
            if (bus.gnt0 || bus.gnt1) got = 1'b1;
        end
        chk("gnt_seen", 32'(got), 1);
        if (!got) begin
            bus.req0 = 1'b0;
            bus.req1 = 1'b0;
            return;
        end
        chk("gnt0", 32'(bus.gnt0), 32'(!v.eid));
        chk("gnt1", 32'(bus.gnt1), 32'(v.eid));
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        w = v.eid ? v.d1 : v.d0;
        for (int k = 0; k < W; k++) begin
            chk("sr_en_shift", 32'(bus.sr_en), 1);
            chk("sr_din", 32'(bus.sr_din), 32'(w[k]));
            chk("done_early", 32'(bus.done), 0);
            if (k == 1) begin
                chk("gnt_pulse_len", 32'(bus.gnt0 | bus.gnt1), 0);
                bus.data0 = v.dlate;
                bus.data1 = v.dlate;
            end
            @(posedge clk); #1;
        end
        chk("sr_en_check", 32'(bus.sr_en), 0);
        chk("busy_check", 32'(bus.busy), 1);
        chk("done_check", 32'(bus.done), 0);
        @(posedge clk); #1;
        chk("done", 32'(bus.done), 1);
        chk("done_id", 32'(bus.done_id), 32'(v.eid));
        chk("rdata", 32'(bus.rdata), 32'(v.erdata));
        chk("match", 32'(bus.match), 32'(v.ematch));
        @(posedge clk); #1;
        chk("done_len", 32'(bus.done), 0);
        chk("busy_idle", 32'(bus.busy), 0);
        chk("rdata_hold", 32'(bus.rdata), 32'(v.erdata));
        chk("done_id_hold", 32'(bus.done_id), 32'(v.eid));
        n_vec++;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_sr_en"},   32'(bus.sr_en), 0);
        chk({tag, "_sr_din"},  32'(bus.sr_din), 0);
        chk({tag, "_gnt"},     32'({bus.gnt1, bus.gnt0}), 0);
        chk({tag, "_busy"},    32'(bus.busy), 0);
        chk({tag, "_done"},    32'(bus.done), 0);
        chk({tag, "_done_id"}, 32'(bus.done_id), 0);
        chk({tag, "_rdata"},   32'(bus.rdata), 0);
        chk({tag, "_match"},   32'(bus.match), 0);
    endtask

    initial begin
        vec_t         v;
        logic         got;
        int           prev_cyc;
        logic [W-1:0] exp_word;

        // r0 r1 d0 d1 dlate stuck eid erdata ematch
        tbl[0] = '{1'b1, 1'b0, 4'hB, 4'h0, 4'h4, 4'h0, 1'b0, 4'hB, 1'b1};
        tbl[1] = '{1'b0, 1'b1, 4'h0, 4'hF, 4'h0, 4'h4, 1'b1, 4'hB, 1'b0};
        tbl[2] = '{1'b1, 1'b1, 4'h3, 4'hC, 4'h0, 4'h0, 1'b0, 4'h3, 1'b1};
        tbl[3] = '{1'b1, 1'b1, 4'h5, 4'h6, 4'hF, 4'h0, 1'b1, 4'h6, 1'b1};
        tbl[4] = '{1'b0, 1'b1, 4'h2, 4'h0, 4'hF, 4'h0, 1'b1, 4'h0, 1'b1};
        tbl[5] = '{1'b1, 1'b1, 4'h9, 4'hA, 4'h0, 4'h0, 1'b0, 4'h9, 1'b1};
        tbl[6] = '{1'b1, 1'b0, 4'h5, 4'h3, 4'hA, 4'h0, 1'b0, 4'h5, 1'b1};

        // Reset with random inputs
        rst_n     = 1'b0;
        stuck     = '0;
        bus.req0  = 1'($urandom);
        bus.req1  = 1'($urandom);
        bus.data0 = W'($urandom);
        bus.data1 = W'($urandom);
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        rst_n    = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            chk("idle_busy", 32'(bus.busy), 0);
            chk("idle_gnt", 32'({bus.gnt1, bus.gnt0}), 0);
        end

        for (int i = 0; i < 7; i++) begin
            run_txn(tbl[i]);
            $display("vec %0d: req=%b%b d0=%h d1=%h -> done_id=%b rdata=%h match=%b",
                     i, tbl[i].r1, tbl[i].r0, tbl[i].d0, tbl[i].d1,
                     bus.done_id, bus.rdata, bus.match);
        end

        // Abort: reset during the second SHIFT cycle of a req0 load
        @(negedge clk);
        bus.req0  = 1'b1;
        bus.data0 = 4'h6;
        stuck     = '0;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(posedge clk); #1;
            if (bus.gnt0 || bus.gnt1) got = 1'b1;
        end
        chk("abort_gnt_seen", 32'(got), 1);
        bus.req0 = 1'b0;
        @(posedge clk); #3;
        chk("abort_pre_sr_en", 32'(bus.sr_en), 1);
        rst_n = 1'b0;
        #1;
        check_all_zero("abort");
        repeat (2) begin
            @(posedge clk); #1;
            chk("abort_no_done", 32'(bus.done), 0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            chk("abort_no_done_post", 32'(bus.done), 0);
            chk("abort_idle", 32'(bus.busy), 0);
        end
        v = '{1'b1, 1'b1, 4'h7, 4'h8, 4'h1, 4'h0, 1'b0, 4'h7, 1'b1};
        run_txn(v);
        $display("abort: post-reset tie -> done_id=%b rdata=%h", bus.done_id, bus.rdata);

        // Contention: both requests held, grants alternate every WIDTH+3 cycles
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n     = 1'b1;
        bus.req0  = 1'b1;
        bus.req1  = 1'b1;
        bus.data0 = 4'h3;
        bus.data1 = 4'hC;
        prev_cyc  = 0;
        for (int t = 0; t < 4; t++) begin
            got = 1'b0;
            for (int i = 0; i < 20 && !got; i++) begin
                @(posedge clk); #1;
                if (bus.gnt0 || bus.gnt1) got = 1'b1;
            end
            chk("cont_gnt_seen", 32'(got), 1);
            chk("cont_gnt1", 32'(bus.gnt1), 32'(t % 2));
            chk("cont_gnt0", 32'(bus.gnt0), 32'(1 - (t % 2)));
            if (t > 0) chk("cont_period", 32'(cyc - prev_cyc), 32'(W + 3));
            prev_cyc = cyc;
            got = 1'b0;
            for (int i = 0; i < 20 && !got; i++) begin
                @(posedge clk); #1;
                if (bus.done) got = 1'b1;
            end
            exp_word = (t % 2 == 1) ? 4'hC : 4'h3;
            chk("cont_done_seen", 32'(got), 1);
            chk("cont_done_id", 32'(bus.done_id), 32'(t % 2));
            chk("cont_rdata", 32'(bus.rdata), 32'(exp_word));
            chk("cont_match", 32'(bus.match), 1);
            $display("contention %0d: done_id=%b rdata=%h match=%b",
                     t, bus.done_id, bus.rdata, bus.match);
            n_vec++;
        end
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        repeat (3) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
